if_fetch_unit: RTL and testbench

//  Instruction-fetch stage of the 5-stage RISC-V core. It is the consumer end of the EX-stage

---
 rtl/if_fetch_unit.sv | 191 +++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage of the 5-stage RISC-V core. Owns the PC register,
//   drives the I-memory request and fills the IF/ID pipeline register. EX
//   redirects (taken branch/jump) flush the fetch. When it is built in, a
//   direct-mapped BTB with 2-bit counters predicts taken branches and is
//   trained by EX feedback.
//
//   Build option: define IF_FETCH_BTB_EN to include the BTB. Without it,
//   prediction outputs are tied to 0, the next PC is always pc+4 and the
//   ex_fb_* inputs are ignored.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   imem_addr_o         fetch address (= PC register)
//   imem_req_o          fetch request, high whenever out of reset
//   imem_rdata_i        instruction word for imem_addr_o
//   imem_stall_i        I-mem not ready, imem_rdata_i invalid this cycle
//   id_stall_i          downstream stall: hold IF/ID and PC
//   ex_redirect_i/_pc_i EX redirect strobe and corrected target
//   ex_fb_*             EX branch resolution (BTB training)
//   pc_o, instr_o, pred_taken_o, pred_target_o, valid_o   IF/ID register
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int               BIT_W     = 32,
  parameter logic [BIT_W-1:0] RESET_PC  = '0,
  parameter int               BTB_IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [BIT_W-1:0] imem_addr_o,
  output logic             imem_req_o,
  input  logic [BIT_W-1:0] imem_rdata_i,
  input  logic             imem_stall_i,
  input  logic             id_stall_i,
  input  logic             ex_redirect_i,
  input  logic [BIT_W-1:0] ex_redirect_pc_i,
  input  logic             ex_fb_valid_i,
  input  logic [BIT_W-1:0] ex_fb_pc_i,
  input  logic             ex_fb_taken_i,
  input  logic [BIT_W-1:0] ex_fb_target_i,
  output logic [BIT_W-1:0] pc_o,
  output logic [BIT_W-1:0] instr_o,
  output logic             pred_taken_o,
  output logic [BIT_W-1:0] pred_target_o,
  output logic             valid_o
);

  typedef enum logic {ST_RUN, ST_KILL} state_t;

  state_t           state_r, state_next;
  logic [BIT_W-1:0] pc_r, pc_next;
  logic [BIT_W-1:0] kill_pc_r, kill_pc_next;
  logic             ifid_load, ifid_bubble;

  logic             pred_taken;
  logic [BIT_W-1:0] pred_target;
  logic             unused_fb;

  assign imem_addr_o = pc_r;
  assign imem_req_o  = rst_n;

`ifdef IF_FETCH_BTB_EN
  localparam int BTB_ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W       = BIT_W - BTB_IDX_W - 2;

  logic             btb_valid_r  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_r    [BTB_ENTRIES];
  logic [BIT_W-1:0] btb_target_r [BTB_ENTRIES];
  logic [1:0]       btb_ctr_r    [BTB_ENTRIES];

  logic [BTB_IDX_W-1:0] lk_idx, fb_idx;
  logic [TAG_W-1:0]     lk_tag, fb_tag;
  logic                 lk_hit, fb_hit;

  assign lk_idx = pc_r[BTB_IDX_W+1:2];
  assign lk_tag = pc_r[BIT_W-1:BTB_IDX_W+2];
  assign lk_hit = btb_valid_r[lk_idx] && (btb_tag_r[lk_idx] == lk_tag);

  assign pred_taken  = lk_hit && btb_ctr_r[lk_idx][1];
  assign pred_target = btb_target_r[lk_idx];

  assign fb_idx = ex_fb_pc_i[BTB_IDX_W+1:2];
  assign fb_tag = ex_fb_pc_i[BIT_W-1:BTB_IDX_W+2];
  assign fb_hit = btb_valid_r[fb_idx] && (btb_tag_r[fb_idx] == fb_tag);

  // Lookup above reads the registered contents, so a same-cycle update to the
  // looked-up index is only visible from the next cycle on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_r[i] <= 1'b0;
        btb_ctr_r[i]   <= 2'b00;
      end
    end else if (ex_fb_valid_i) begin
      if (fb_hit) begin
        if (ex_fb_taken_i) begin
          if (btb_ctr_r[fb_idx] != 2'b11)
            btb_ctr_r[fb_idx] <= btb_ctr_r[fb_idx] + 2'd1;
          btb_target_r[fb_idx] <= ex_fb_target_i;
        end else if (btb_ctr_r[fb_idx] != 2'b00) begin
          btb_ctr_r[fb_idx] <= btb_ctr_r[fb_idx] - 2'd1;
        end
      end else if (ex_fb_taken_i) begin
        // New entries start weakly taken.
        btb_valid_r[fb_idx]  <= 1'b1;
        btb_tag_r[fb_idx]    <= fb_tag;
        btb_target_r[fb_idx] <= ex_fb_target_i;
        btb_ctr_r[fb_idx]    <= 2'b10;
      end
    end
  end

  assign unused_fb = ^ex_fb_pc_i[1:0];
`else
  assign pred_taken  = 1'b0;
  assign pred_target = '0;
  assign unused_fb   = ^{ex_fb_valid_i, ex_fb_pc_i, ex_fb_taken_i,
                         ex_fb_target_i, pc_r[BTB_IDX_W+1:2]};
`endif

  // Next-state / next-PC. KILL exists because a redirect that arrives while
  // I-mem is stalled cannot be issued yet: the outstanding (stale) word must
  // first be drained and thrown away.
  always_comb begin
    state_next   = state_r;
    pc_next      = pc_r;
    kill_pc_next = kill_pc_r;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (ex_redirect_i) begin
          // Redirect wins over id_stall_i: the slot is flushed regardless.
          ifid_bubble = 1'b1;
          if (imem_stall_i) begin
            kill_pc_next = ex_redirect_pc_i;
            state_next   = ST_KILL;
          end else begin
            pc_next = ex_redirect_pc_i;
          end
        end else if (id_stall_i) begin
          // hold PC and IF/ID
        end else if (imem_stall_i) begin
          ifid_bubble = 1'b1;
        end else begin
          ifid_load = 1'b1;
          pc_next   = pred_taken ? pred_target : pc_r + BIT_W'(4);
        end
      end
      ST_KILL: begin
        ifid_bubble = 1'b1;
        if (ex_redirect_i)
          kill_pc_next = ex_redirect_pc_i;
        if (!imem_stall_i) begin
          // Latest redirect wins, including one arriving on this very cycle.
          pc_next    = ex_redirect_i ? ex_redirect_pc_i : kill_pc_r;
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      pc_r          <= RESET_PC;
      kill_pc_r     <= '0;
      pc_o          <= '0;
      instr_o       <= '0;
      pred_taken_o  <= 1'b0;
      pred_target_o <= '0;
      valid_o       <= 1'b0;
    end else begin
      state_r   <= state_next;
      pc_r      <= pc_next;
      kill_pc_r <= kill_pc_next;
      if (ifid_load) begin
        pc_o          <= pc_r;
        instr_o       <= imem_rdata_i;
        pred_taken_o  <= pred_taken;
        pred_target_o <= pred_taken ? pred_target : '0;
        valid_o       <= 1'b1;
      end else if (ifid_bubble) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//   Directed scenarios followed by randomized stimulus, every cycle compared
//   against a behavioural model of the fetch stage and BTB. The instruction
//   memory returns addr ^ IMEM_KEY, and random junk while stalled.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] IMEM_KEY = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr_o;
  logic        imem_req_o;
  logic [31:0] imem_rdata_i;
  logic        imem_stall_i;
  logic        id_stall_i;
  logic        ex_redirect_i;
  logic [31:0] ex_redirect_pc_i;
  logic        ex_fb_valid_i;
  logic [31:0] ex_fb_pc_i;
  logic        ex_fb_taken_i;
  logic [31:0] ex_fb_target_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        valid_o;
  logic [31:0] junk_word;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_rdata_i = imem_stall_i ? junk_word : (imem_addr_o ^ IMEM_KEY);

  if_fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_addr_o      (imem_addr_o),
    .imem_req_o       (imem_req_o),
    .imem_rdata_i     (imem_rdata_i),
    .imem_stall_i     (imem_stall_i),
    .id_stall_i       (id_stall_i),
    .ex_redirect_i    (ex_redirect_i),
    .ex_redirect_pc_i (ex_redirect_pc_i),
    .ex_fb_valid_i    (ex_fb_valid_i),
    .ex_fb_pc_i       (ex_fb_pc_i),
    .ex_fb_taken_i    (ex_fb_taken_i),
    .ex_fb_target_i   (ex_fb_target_i),
    .pc_o             (pc_o),
    .instr_o          (instr_o),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .valid_o          (valid_o)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_kill_pc, m_pc_o, m_instr, m_ptgt;
  bit          m_kill, m_pt, m_valid;
  // BTB: each entry remembers the full PC that allocated it; tag match is
  // "same PC above the index bits".
  bit          b_v   [16];
  logic [31:0] b_pc  [16];
  logic [31:0] b_tgt [16];
  int          b_ctr [16];

  function automatic int idx_of(logic [31:0] a);
    return int'((a >> 2) & 32'hF);
  endfunction

  function automatic bit same_tag(logic [31:0] a, logic [31:0] b);
    return (a >> 6) == (b >> 6);
  endfunction

  task automatic model_update();
    bit          pt;
    logic [31:0] ptgt;
    int          ix;
    if (!rst_n) begin
      m_pc = 32'h0; m_kill = 0; m_kill_pc = 32'h0;
      m_pc_o = 32'h0; m_instr = 32'h0; m_pt = 0; m_ptgt = 32'h0; m_valid = 0;
      for (int i = 0; i < 16; i++) begin b_v[i] = 0; b_ctr[i] = 0; end
      return;
    end
    pt = 0;
    ptgt = 32'h0;
`ifdef IF_FETCH_BTB_EN
    ix = idx_of(m_pc);
    if (b_v[ix] && same_tag(b_pc[ix], m_pc) && b_ctr[ix] >= 2) begin
      pt = 1;
      ptgt = b_tgt[ix];
    end
`endif
    if (m_kill) begin
      m_valid = 0;
      if (ex_redirect_i) m_kill_pc = ex_redirect_pc_i;
      if (!imem_stall_i) begin
        m_pc = m_kill_pc;
        m_kill = 0;
      end
    end else if (ex_redirect_i) begin
      m_valid = 0;
      if (imem_stall_i) begin
        m_kill = 1;
        m_kill_pc = ex_redirect_pc_i;
      end else begin
        m_pc = ex_redirect_pc_i;
      end
    end else if (id_stall_i) begin
      // everything holds
    end else if (imem_stall_i) begin
      m_valid = 0;
    end else begin
      m_pc_o = m_pc;
      m_instr = m_pc ^ IMEM_KEY;
      m_pt = pt;
      m_ptgt = ptgt;
      m_valid = 1;
      m_pc = pt ? ptgt : m_pc + 32'd4;
    end
`ifdef IF_FETCH_BTB_EN
    if (ex_fb_valid_i) begin
      ix = idx_of(ex_fb_pc_i);
      if (b_v[ix] && same_tag(b_pc[ix], ex_fb_pc_i)) begin
        if (ex_fb_taken_i) begin
          b_ctr[ix] = (b_ctr[ix] < 3) ? b_ctr[ix] + 1 : 3;
          b_tgt[ix] = ex_fb_target_i;
        end else begin
          b_ctr[ix] = (b_ctr[ix] > 0) ? b_ctr[ix] - 1 : 0;
        end
      end else if (ex_fb_taken_i) begin
        b_v[ix] = 1;
        b_pc[ix] = ex_fb_pc_i;
        b_tgt[ix] = ex_fb_target_i;
        b_ctr[ix] = 2;
      end
    end
`endif
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("m_imem_addr", imem_addr_o, m_pc);
    chk("m_imem_req", 32'(imem_req_o), 32'(rst_n));
    chk("m_valid", 32'(valid_o), 32'(m_valid));
    if (m_valid) begin
      chk("m_pc_o", pc_o, m_pc_o);
      chk("m_instr", instr_o, m_instr);
      chk("m_pred_taken", 32'(pred_taken_o), 32'(m_pt));
      if (m_pt) chk("m_pred_target", pred_target_o, m_ptgt);
    end
`ifndef IF_FETCH_BTB_EN
    chk("nobtb_pred_taken", 32'(pred_taken_o), 32'h0);
    chk("nobtb_pred_target", pred_target_o, 32'h0);
`endif
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    imem_stall_i = 0; id_stall_i = 0; ex_redirect_i = 0; ex_redirect_pc_i = 0;
    ex_fb_valid_i = 0; ex_fb_pc_i = 0; ex_fb_taken_i = 0; ex_fb_target_i = 0;
  endtask

  logic [31:0] held_addr, held_pc, held_instr;
  bit          btb_on;

  initial begin
`ifdef IF_FETCH_BTB_EN
    btb_on = 1;
`else
    btb_on = 0;
`endif
    junk_word = 32'hDEAD_BEEF;
    rst_n = 0;
    idle_inputs();

    // 1: reset then free-running fetch
    step(); step();
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_req", 32'(imem_req_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pred_taken", 32'(pred_taken_o), 32'h0);
    chk("rst_pred_target", pred_target_o, 32'h0);
    rst_n = 1;
    #1;
    chk("t1_req", 32'(imem_req_o), 32'h1);
    step();
    chk("t1_addr4", imem_addr_o, 32'h4);
    chk("t1_pc_o0", pc_o, 32'h0);
    chk("t1_valid", 32'(valid_o), 32'h1);
    chk("t1_instr", instr_o, 32'h0 ^ IMEM_KEY);
    step();
    chk("t1_addr8", imem_addr_o, 32'h8);
    chk("t1_pc_o4", pc_o, 32'h4);
    $display("scenario reset/sequential fetch done, checks=%0d", n_checks);

    // 2: redirect
    ex_redirect_i = 1; ex_redirect_pc_i = 32'h100;
    step();
    chk("t2_addr", imem_addr_o, 32'h100);
    chk("t2_bubble", 32'(valid_o), 32'h0);
    ex_redirect_i = 0;
    step();
    chk("t2_pc_o", pc_o, 32'h100);
    chk("t2_valid", 32'(valid_o), 32'h1);
    chk("t2_addr_next", imem_addr_o, 32'h104);
    $display("scenario redirect done, checks=%0d", n_checks);

    // 5: ID stall for two cycles
    held_addr = imem_addr_o; held_pc = pc_o; held_instr = instr_o;
    id_stall_i = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t5_addr_hold", imem_addr_o, held_addr);
      chk("t5_pc_hold", pc_o, held_pc);
      chk("t5_instr_hold", instr_o, held_instr);
      chk("t5_valid_hold", 32'(valid_o), 32'h1);
    end
    id_stall_i = 0;
    step();
    chk("t5_resume_pc", pc_o, held_addr);
    chk("t5_resume_addr", imem_addr_o, held_addr + 32'd4);
    $display("scenario id stall done, checks=%0d", n_checks);

    // 4: I-mem stall with redirect in its first cycle
    held_addr = imem_addr_o;
    imem_stall_i = 1; ex_redirect_i = 1; ex_redirect_pc_i = 32'h200;
    junk_word = 32'hBAD0_0001;
    for (int i = 0; i < 3; i++) begin
      step();
      ex_redirect_i = 0;
      chk("t4_valid_low", 32'(valid_o), 32'h0);
      chk("t4_addr_hold", imem_addr_o, held_addr);
    end
    imem_stall_i = 0;
    step();
    chk("t4_addr_target", imem_addr_o, 32'h200);
    chk("t4_stale_dropped", 32'(valid_o), 32'h0);
    step();
    chk("t4_pc_o", pc_o, 32'h200);
    chk("t4_instr", instr_o, 32'h200 ^ IMEM_KEY);
    chk("t4_valid", 32'(valid_o), 32'h1);
    $display("scenario imem stall + redirect done, checks=%0d", n_checks);

    // 3 / 6: BTB training and prediction
    ex_fb_valid_i = 1; ex_fb_pc_i = 32'h20; ex_fb_taken_i = 1; ex_fb_target_i = 32'h80;
    step();
    ex_fb_valid_i = 0;
    ex_redirect_i = 1; ex_redirect_pc_i = 32'h20;
    step();
    chk("t3_addr_20", imem_addr_o, 32'h20);
    ex_redirect_i = 0;
    step();
    chk("t3_pc_o", pc_o, 32'h20);
    chk("t3_pred_taken", 32'(pred_taken_o), btb_on ? 32'h1 : 32'h0);
    chk("t3_pred_target", pred_target_o, btb_on ? 32'h80 : 32'h0);
    chk("t3_next_addr", imem_addr_o, btb_on ? 32'h80 : 32'h24);
    ex_fb_valid_i = 1; ex_fb_pc_i = 32'h20; ex_fb_taken_i = 0;
    step(); step();
    ex_fb_valid_i = 0;
    ex_redirect_i = 1; ex_redirect_pc_i = 32'h20;
    step();
    ex_redirect_i = 0;
    step();
    chk("t3_nt_pc_o", pc_o, 32'h20);
    chk("t3_nt_pred", 32'(pred_taken_o), 32'h0);
    chk("t3_nt_addr", imem_addr_o, 32'h24);
    $display("scenario btb train/untrain done, checks=%0d", n_checks);

    // Randomized phase against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n            = ($urandom_range(0, 199) != 0);
      ex_redirect_i    = ($urandom_range(0, 9) == 0);
      ex_redirect_pc_i = 32'($urandom_range(0, 127)) << 2;
      imem_stall_i     = ($urandom_range(0, 3) == 0);
      id_stall_i       = ($urandom_range(0, 4) == 0);
      ex_fb_valid_i    = ($urandom_range(0, 2) == 0);
      ex_fb_pc_i       = 32'($urandom_range(0, 63)) << 2;
      ex_fb_taken_i    = ($urandom_range(0, 2) != 0);
      ex_fb_target_i   = 32'($urandom_range(0, 127)) << 2;
      junk_word        = $urandom;
      step();
    end
    $display("scenario random 3000 cycles done, checks=%0d", n_checks);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
